mem_arbiter: RTL and testbench

//  Shares the single 128-bit main-memory port between the I-cache refill path and the D-cache refill/writeback path.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the I-cache, D-cache and main-memory signals that
//               meet at the memory arbiter. The master modport is the
//               arbiter's view; the slave modport is the caches/memory view.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    // I-cache refill path
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;
    // D-cache refill / writeback path
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;
    // Main memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single main-memory line port between the I-cache
//               refill path and the D-cache refill/writeback path. One
//               requester is granted at a time; address, write flag and data
//               are registered for the whole transaction and completion is
//               signalled with a one-cycle ready pulse.
//               Optional macro ARB_ROUND_ROBIN_EN: alternate grants between
//               simultaneous requesters (default: D-cache has priority).
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  wire           clk,
    input  wire           rst_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_pick_d;
    logic              w_pick_i;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    // High when the D side won the most recent grant; starts on the I side
    logic r_last_grant_d;

    // Track the last winner so simultaneous requests alternate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant_d <= 1'b0;
        end else if (r_state == ST_IDLE && (w_pick_d || w_pick_i)) begin
            r_last_grant_d <= w_pick_d;
        end
    end

    // A lone requester always wins; on a tie the side not granted last wins
    assign w_pick_d = bus.d_req && (!bus.i_req || !r_last_grant_d);
`else
    // Fixed priority: the D side wins whenever it is requesting
    assign w_pick_d = bus.d_req;
`endif
    assign w_pick_i = bus.i_req && !w_pick_d;

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: grant in IDLE, wait for ack in BUSY, one DONE cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_d) begin
                    w_state_next = ST_BUSY_D;
                end else if (w_pick_i) begin
                    w_state_next = ST_BUSY_I;
                end
            end
            ST_BUSY_I: begin
                if (bus.mem_ack) begin
                    w_state_next = ST_DONE_I;
                end
            end
            ST_BUSY_D: begin
                if (bus.mem_ack) begin
                    w_state_next = ST_DONE_D;
                end
            end
            ST_DONE_I,
            ST_DONE_D: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request and capture read data on acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_pick_d) begin
                    r_addr  <= bus.d_addr;
                    r_we    <= bus.d_we;
                    r_wdata <= bus.d_wdata;
                end else if (w_pick_i) begin
                    r_addr  <= bus.i_addr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if (r_state == ST_BUSY_I && bus.mem_ack) begin
                r_i_rdata <= bus.mem_rdata;
            end
            // A writeback leaves the D-side read data untouched
            if (r_state == ST_BUSY_D && bus.mem_ack && !r_we) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

    // All outputs come from registers or state decode only
    assign bus.mem_req   = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.i_ready   = (r_state == ST_DONE_I);
    assign bus.d_ready   = (r_state == ST_DONE_D);
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: vector table for single
//               transactions, hand-written sequences for reset, spurious ack,
//               request change while busy and simultaneous requests, with a
//               scoreboard of expected grants/completions and a memory model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_msg(input string name, input string why);
        n_checks++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Memory contents model
    function automatic logic [127:0] mem_line(input logic [31:0] a);
        if (a == 32'h0000_1230) return {32{4'hA}};
        return {a, ~a, a ^ 32'hDEAD_BEEF, 32'h1234_0000 | {16'h0, a[15:0]}};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit           is_d;
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_i;
        logic [127:0] exp_d;
    } txn_t;

    txn_t         sb[$];
    logic [127:0] m_i = '0;
    logic [127:0] m_d = '0;

    task automatic sb_push(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [127:0] wdata);
        txn_t e;
        if (!is_d) m_i = mem_line(addr);
        else if (!we) m_d = mem_line(addr);
        e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata;
        e.exp_i = m_i; e.exp_d = m_d;
        sb.push_back(e);
    endtask

    // ---------------- memory responder ----------------
    int ack_dly  = 0;
    bit auto_ack = 1'b1;
    bit spur     = 1'b0;
    int rsp_wc   = 0;
    bit rsp_sent = 1'b0;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_ack   = 1'b0;
            if (!auto_ack) begin
                if (spur) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = {4{32'hBAD0_BAD0}};
                end
            end else if (bus.mem_req && !rsp_sent) begin
                if (rsp_wc >= ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_line(bus.mem_addr);
                    rsp_sent      = 1'b1;
                end else begin
                    rsp_wc++;
                end
            end
            if (!bus.mem_req) begin
                rsp_wc   = 0;
                rsp_sent = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    bit mon_prev_req = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_req = 1'b0;
            end else begin
                if (bus.mem_req) begin
                    if (sb.size() == 0) begin
                        fail_msg("unexpected_grant", $sformatf("mem_req high at addr %h with nothing expected", bus.mem_addr));
                    end else begin
                        chk(mon_prev_req ? "hold_addr" : "grant_addr", bus.mem_addr, sb[0].addr);
                        chk(mon_prev_req ? "hold_we" : "grant_we", bus.mem_we, sb[0].we);
                        if (sb[0].is_d)
                            chk(mon_prev_req ? "hold_wdata" : "grant_wdata", bus.mem_wdata, sb[0].wdata);
                    end
                end
                if (bus.i_ready || bus.d_ready) begin
                    if (sb.size() == 0) begin
                        fail_msg("unexpected_ready", $sformatf("i_ready=%0b d_ready=%0b with nothing expected", bus.i_ready, bus.d_ready));
                    end else begin
                        txn_t e;
                        e = sb.pop_front();
                        chk("ready_side", {bus.d_ready, bus.i_ready}, e.is_d ? 2'b10 : 2'b01);
                        chk("i_rdata", bus.i_rdata, e.exp_i);
                        chk("d_rdata", bus.d_rdata, e.exp_d);
                    end
                end
                mon_prev_req = bus.mem_req;
            end
        end
    end

    // ---------------- drivers ----------------
    // One complete transaction; latency counted in cycles from request to ready inclusive.
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [127:0] wd, input int dly, input int exp_lat,
                           input bit exp_we, input bit chg);
        int cyc;
        bit done;
        ack_dly = dly;
        sb_push(is_d, exp_we, addr, wd);
        @(negedge clk);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (chg && cyc == 2) begin
                bus.i_addr  = addr ^ 32'hFFFF_0000;
                bus.d_addr  = addr ^ 32'h0F0F_0000;
                bus.d_wdata = ~wd;
            end
            if (is_d ? bus.d_ready : bus.i_ready) begin
                done = 1'b1;
                chk("latency", cyc + 1, exp_lat);
            end
        end
        if (!done) fail_msg("ready_timeout", $sformatf("no ready for addr %h", addr));
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    // Requester that keeps its request line up and issues the next line on each ready
    task automatic stream(input bit is_d, input int n, input logic [31:0] base);
        int k = 0;
        int guard = 0;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = base; bus.d_wdata = {4{base}};
        end else begin
            bus.i_req = 1'b1; bus.i_addr = base;
        end
        while (k < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (is_d ? bus.d_ready : bus.i_ready) begin
                k++;
                if (is_d) begin
                    if (k < n) begin
                        bus.d_addr = base + 32'(k * 16); bus.d_wdata = {4{base + 32'(k * 16)}};
                    end else bus.d_req = 1'b0;
                end else begin
                    if (k < n) bus.i_addr = base + 32'(k * 16);
                    else bus.i_req = 1'b0;
                end
            end
        end
        if (k < n) fail_msg(is_d ? "d_stream_timeout" : "i_stream_timeout", "requests not all serviced");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           is_d;
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           dly;
        int           exp_lat;
        bit           exp_we;
    } vec_t;

    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // {is_d, we, addr, wdata, ack delay, expected latency, expected mem_we}
        vt[0] = '{1'b0, 1'b0, 32'h0000_1230, 128'h0,        1, 4, 1'b0};
        vt[1] = '{1'b1, 1'b0, 32'h0000_3000, {4{32'h7777_0001}}, 0, 3, 1'b0};
        vt[2] = '{1'b1, 1'b1, 32'h0000_2000, {32{4'h5}},    2, 5, 1'b1};
        vt[3] = '{1'b0, 1'b0, 32'h0000_4440, 128'h0,        0, 3, 1'b0};
        vt[4] = '{1'b1, 1'b1, 32'h0000_2010, {4{32'hC0DE_F00D}}, 0, 3, 1'b1};
        vt[5] = '{1'b0, 1'b0, 32'h0000_5550, 128'h0,        3, 6, 1'b0};
        vt[6] = '{1'b0, 1'b0, 32'h0000_6000, 128'h0,        0, 3, 1'b0};
        vt[7] = '{1'b0, 1'b0, 32'h0000_6010, 128'h0,        0, 3, 1'b0};
        vt[8] = '{1'b0, 1'b0, 32'h0000_6020, 128'h0,        0, 3, 1'b0};

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
        chk("rst_i_ready", bus.i_ready, 1'b0);
        chk("rst_d_ready", bus.d_ready, 1'b0);
        chk("rst_i_rdata", bus.i_rdata, 128'h0);
        chk("rst_d_rdata", bus.d_rdata, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transactions: read timing, writeback, zero-wait memory
        for (int v = 0; v < 9; v++)
            run_txn(vt[v].is_d, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].dly,
                    vt[v].exp_lat, vt[v].exp_we, 1'b0);

        // Spurious acknowledge while idle
        auto_ack = 1'b0;
        @(posedge clk); #2 spur = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 spur = 1'b0;
        @(negedge clk);
        chk("spur_mem_req", bus.mem_req, 1'b0);
        chk("spur_i_ready", bus.i_ready, 1'b0);
        chk("spur_d_ready", bus.d_ready, 1'b0);
        @(negedge clk);
        chk("spur_i_rdata", bus.i_rdata, m_i);
        chk("spur_d_rdata", bus.d_rdata, m_d);
        auto_ack = 1'b1;

        // Request inputs change while busy: latched values must hold
        run_txn(1'b0, 1'b0, 32'h0000_A5A0, 128'h0, 3, 6, 1'b0, 1'b1);
        run_txn(1'b1, 1'b1, 32'h0000_B000, {4{32'h1357_9BDF}}, 3, 6, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a D transaction
        ack_dly = 20;
        sb_push(1'b1, 1'b0, 32'h0000_7000, 128'h0);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_7000; bus.d_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_mem_req", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 1'b0);
        chk("async_rst_d_ready", bus.d_ready, 1'b0);
        chk("async_rst_mem_addr", bus.mem_addr, 32'h0);
        chk("async_rst_i_rdata", bus.i_rdata, 128'h0);
        sb.delete();
        m_i = '0;
        m_d = '0;
        bus.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_d_ready", bus.d_ready, 1'b0);
            chk("post_rst_mem_req", bus.mem_req, 1'b0);
        end

        // Simultaneous requests, each side issuing three lines
        ack_dly = 1;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) begin
            sb_push(1'b1, 1'b0, 32'h0000_8000 + 32'(k * 16), {4{32'h0000_8000 + 32'(k * 16)}});
            sb_push(1'b0, 1'b0, 32'h0000_9000 + 32'(k * 16), 128'h0);
        end
`else
        for (int k = 0; k < 3; k++)
            sb_push(1'b1, 1'b0, 32'h0000_8000 + 32'(k * 16), {4{32'h0000_8000 + 32'(k * 16)}});
        for (int k = 0; k < 3; k++)
            sb_push(1'b0, 1'b0, 32'h0000_9000 + 32'(k * 16), 128'h0);
`endif
        @(negedge clk);
        fork
            stream(1'b1, 3, 32'h0000_8000);
            stream(1'b0, 3, 32'h0000_9000);
        join

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
